// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared phase constants, CPU arbiter states and fetch address helper
package video_pkg;

   localparam int VRAM_AW = 14;

   localparam logic [2:0] PH_CHAR_A = 3'd0;
   localparam logic [2:0] PH_ATTR_A = 3'd1;
   localparam logic [2:0] PH_ATTR_D = 3'd2;
   localparam logic [2:0] PH_LAST   = 3'd7;

   typedef enum logic [1:0] {
      CPU_IDLE,
      CPU_PENDING,
      CPU_DONE
   } cpu_state_t;

   // Graphics mode interleaves the two scanline banks on row_addr bit 0.
   function automatic logic [VRAM_AW-1:0] fetch_base(input logic gfx, input logic ma_hi,
                                                     input logic [11:0] ma_lo, input logic ra0);
      return gfx ? {ra0, ma_lo, 1'b0} : {ma_hi, ma_lo, 1'b0};
   endfunction

endpackage

// File: rtl/vram_phase_gen.sv
// rtl/vram_phase_gen.sv - 8-phase character-clock sequencer with CRTC divclk and CPU slot decode
module vram_phase_gen
   import video_pkg::*;
#(
   parameter int CPU_SLOT = 4
) (
   input  logic       clk,
   input  logic       reset,
   output logic [2:0] phase,
   output logic       crtc_ce,
   output logic       cpu_slot
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= 3'd0;
      end else begin
         phase <= phase + 3'd1;
      end
   end

   assign crtc_ce  = (phase == PH_LAST);
   assign cpu_slot = (phase == 3'(CPU_SLOT));

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - time-division VRAM arbiter between CRTC char/attr fetch and CPU accesses
module vram_arbiter
   import video_pkg::*;
#(
   parameter int ADDR_WIDTH = VRAM_AW,
   parameter int CPU_SLOT   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  crtc_ce,
   input  logic [13:0]           crtc_ma,
   input  logic [4:0]            crtc_ra,
   input  logic                  gfx_mode,
   output logic [7:0]            char_q,
   output logic [7:0]            attr_q,
   output logic                  fetch_valid,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [7:0]            cpu_din,
   output logic [7:0]            cpu_dout,
   output logic                  cpu_ready,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [7:0]            ram_din,
   input  logic [7:0]            ram_dout
);

   logic [2:0]            phase;
   logic                  ph_slot;
   cpu_state_t            state;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic                  lat_we;
   logic [7:0]            lat_din;
   logic                  req_armed;
   logic [7:0]            char_hold;
   logic [7:0]            attr_hold;
   logic [7:0]            cpu_dout_q;
   logic [ADDR_WIDTH-1:0] ram_addr_q;
   logic [7:0]            ram_din_q;
   logic [ADDR_WIDTH-1:0] ram_addr_c;
   logic [ADDR_WIDTH-1:0] base;
   logic                  unused_bits;

   vram_phase_gen #(.CPU_SLOT(CPU_SLOT)) u_phase (
      .clk      (clk),
      .reset    (reset),
      .phase    (phase),
      .crtc_ce  (crtc_ce),
      .cpu_slot (ph_slot)
   );

   assign base        = ADDR_WIDTH'(fetch_base(gfx_mode, crtc_ma[12], crtc_ma[11:0], crtc_ra[0]));
   assign unused_bits = ^{crtc_ma[13], crtc_ra[4:1]};

   // Idle phases keep the previous address on the bus rather than glitching it.
   always_comb begin
      ram_addr_c = ram_addr_q;
      ram_we     = 1'b0;
      ram_din    = ram_din_q;
      if (phase == PH_CHAR_A) begin
         ram_addr_c = base;
      end else if (phase == PH_ATTR_A) begin
         ram_addr_c = base + ADDR_WIDTH'(1);
      end else if (ph_slot && state == CPU_PENDING) begin
         ram_addr_c = lat_addr;
         ram_we     = lat_we;
         ram_din    = lat_din;
      end
   end

   assign ram_addr    = reset ? '0 : ram_addr_c;
   assign fetch_valid = crtc_ce;
   assign cpu_ready   = (state == CPU_DONE);
   assign cpu_dout    = (state == CPU_DONE && !lat_we) ? ram_dout : cpu_dout_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= CPU_IDLE;
         lat_addr   <= '0;
         lat_we     <= 1'b0;
         lat_din    <= 8'd0;
         req_armed  <= 1'b1;
         char_hold  <= 8'd0;
         attr_hold  <= 8'd0;
         char_q     <= 8'd0;
         attr_q     <= 8'd0;
         cpu_dout_q <= 8'd0;
         ram_addr_q <= '0;
         ram_din_q  <= 8'd0;
      end else begin
         ram_addr_q <= ram_addr_c;
         ram_din_q  <= ram_din;
         if (phase == PH_ATTR_A) char_hold <= ram_dout;
         if (phase == PH_ATTR_D) attr_hold <= ram_dout;
         // Load on the edge into phase 7 so the new bytes coincide with crtc_ce.
         if (phase == PH_LAST - 3'd1) begin
            char_q <= char_hold;
            attr_q <= attr_hold;
         end
         if (!cpu_req) req_armed <= 1'b1;
         case (state)
            CPU_IDLE: begin
               if (cpu_req && req_armed) begin
                  lat_addr <= cpu_addr;
                  lat_we   <= cpu_we;
                  lat_din  <= cpu_din;
                  state    <= CPU_PENDING;
               end
            end
            CPU_PENDING: begin
               if (ph_slot) state <= CPU_DONE;
            end
            CPU_DONE: begin
               if (!lat_we) cpu_dout_q <= ram_dout;
               req_armed <= ~cpu_req;
               state     <= CPU_IDLE;
            end
            default: state <= CPU_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;

   logic        clk;
   logic        reset;
   logic        crtc_ce;
   logic [13:0] crtc_ma;
   logic [4:0]  crtc_ra;
   logic        gfx_mode;
   logic [7:0]  char_q;
   logic [7:0]  attr_q;
   logic        fetch_valid;
   logic        cpu_req;
   logic        cpu_we;
   logic [13:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic [7:0]  cpu_dout;
   logic        cpu_ready;
   logic [13:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;

   logic [7:0]  mem [0:16383];
   logic        pl_we;
   logic [13:0] pl_addr;
   logic [7:0]  pl_data;
   logic [2:0]  tb_ph;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        gfx;
      logic [13:0] ma;
      logic [4:0]  ra;
      logic [13:0] a0;
      logic [13:0] a1;
      logic [7:0]  ch;
      logic [7:0]  at;
   } vec_t;

   vec_t vec [7];

   vram_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .crtc_ce     (crtc_ce),
      .crtc_ma     (crtc_ma),
      .crtc_ra     (crtc_ra),
      .gfx_mode    (gfx_mode),
      .char_q      (char_q),
      .attr_q      (attr_q),
      .fetch_valid (fetch_valid),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_din     (cpu_din),
      .cpu_dout    (cpu_dout),
      .cpu_ready   (cpu_ready),
      .ram_addr    (ram_addr),
      .ram_we      (ram_we),
      .ram_din     (ram_din),
      .ram_dout    (ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pl_we) mem[pl_addr] <= pl_data;
      else if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   always @(posedge clk or posedge reset) begin
      if (reset) tb_ph <= 3'd0;
      else tb_ph <= tb_ph + 3'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (phase %0d)", name, act, exp, tb_ph);
      end
   endtask

   task automatic preload(input logic [13:0] a, input logic [7:0] d);
      pl_addr = a;
      pl_data = d;
      pl_we   = 1'b1;
      @(negedge clk);
      pl_we   = 1'b0;
   endtask

   task automatic goto_ph(input logic [2:0] p);
      int n;
      n = 0;
      while (tb_ph != p && n < 16) begin
         @(negedge clk);
         n++;
      end
      if (tb_ph != p) begin
         checks++;
         errors++;
         $display("FAIL goto_ph timeout waiting for phase %0d", p);
      end
   endtask

   initial begin
      int bad;
      vec[0] = '{1'b0, 14'h0050, 5'd0, 14'h00A0, 14'h00A1, 8'h41, 8'h1F};
      vec[1] = '{1'b1, 14'h0010, 5'd1, 14'h2020, 14'h2021, 8'h12, 8'h34};
      vec[2] = '{1'b0, 14'h1FFF, 5'd3, 14'h3FFE, 14'h3FFF, 8'h56, 8'h78};
      vec[3] = '{1'b0, 14'h2005, 5'd0, 14'h000A, 14'h000B, 8'h9A, 8'hBC};
      vec[4] = '{1'b1, 14'h0FFF, 5'd0, 14'h1FFE, 14'h1FFF, 8'hDE, 8'hF0};
      vec[5] = '{1'b1, 14'h1ABC, 5'd2, 14'h1578, 14'h1579, 8'h11, 8'h22};
      vec[6] = '{1'b1, 14'h0800, 5'd3, 14'h3000, 14'h3001, 8'h33, 8'h44};

      reset    = 1'b1;
      pl_we    = 1'b0;
      pl_addr  = '0;
      pl_data  = '0;
      crtc_ma  = 14'h0050;
      crtc_ra  = 5'd0;
      gfx_mode = 1'b0;
      cpu_req  = 1'b0;
      cpu_we   = 1'b0;
      cpu_addr = '0;
      cpu_din  = '0;

      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         preload(vec[i].a0, vec[i].ch);
         preload(vec[i].a1, vec[i].at);
      end
      preload(14'h0003, 8'h77);
      preload(14'h0100, 8'h00);
      preload(14'h1234, 8'h00);

      #1;
      chk("rst_ram_addr", 32'(ram_addr), 32'h0);
      chk("rst_ram_we", 32'(ram_we), 32'h0);
      chk("rst_ram_din", 32'(ram_din), 32'h0);
      chk("rst_crtc_ce", 32'(crtc_ce), 32'h0);
      chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
      chk("rst_char_q", 32'(char_q), 32'h0);
      chk("rst_attr_q", 32'(attr_q), 32'h0);
      chk("rst_cpu_ready", 32'(cpu_ready), 32'h0);
      chk("rst_cpu_dout", 32'(cpu_dout), 32'h0);

      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("first_phase0_addr", 32'(ram_addr), 32'h00A0);

      for (int i = 0; i < 7; i++) begin
         goto_ph(3'd7);
         crtc_ma  = vec[i].ma;
         crtc_ra  = vec[i].ra;
         gfx_mode = vec[i].gfx;
         @(negedge clk); #1;
         chk($sformatf("v%0d_addr_ph0", i), 32'(ram_addr), 32'(vec[i].a0));
         chk($sformatf("v%0d_we_ph0", i), 32'(ram_we), 32'h0);
         chk($sformatf("v%0d_ce_ph0", i), 32'(crtc_ce), 32'h0);
         @(negedge clk); #1;
         chk($sformatf("v%0d_addr_ph1", i), 32'(ram_addr), 32'(vec[i].a1));
         goto_ph(3'd7); #1;
         chk($sformatf("v%0d_char_q", i), 32'(char_q), 32'(vec[i].ch));
         chk($sformatf("v%0d_attr_q", i), 32'(attr_q), 32'(vec[i].at));
         chk($sformatf("v%0d_fetch_valid", i), 32'(fetch_valid), 32'h1);
         chk($sformatf("v%0d_crtc_ce", i), 32'(crtc_ce), 32'h1);
      end

      crtc_ma  = 14'h0050;
      crtc_ra  = 5'd0;
      gfx_mode = 1'b0;

      // CPU write requested at phase 5: served at the next phase 4, ready 8 cycles later.
      goto_ph(3'd5);
      cpu_req  = 1'b1;
      cpu_we   = 1'b1;
      cpu_addr = 14'h1234;
      cpu_din  = 8'hA5;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 3) begin
            cpu_addr = 14'h0BAD;
            cpu_din  = 8'h00;
            cpu_we   = 1'b0;
         end
         #1;
         chk($sformatf("wr_we_k%0d", k), 32'(ram_we), (k == 7) ? 32'h1 : 32'h0);
         chk($sformatf("wr_ready_k%0d", k), 32'(cpu_ready), (k == 8) ? 32'h1 : 32'h0);
         if (k == 3) chk("wr_fetch_addr_ph0", 32'(ram_addr), 32'h00A0);
         if (k == 4) chk("wr_fetch_addr_ph1", 32'(ram_addr), 32'h00A1);
         if (k == 7) begin
            chk("wr_slot_addr", 32'(ram_addr), 32'h1234);
            chk("wr_slot_din", 32'(ram_din), 32'hA5);
         end
      end
      @(negedge clk);
      cpu_req = 1'b0;
      #1;
      chk("wr_mem_content", 32'(mem[14'h1234]), 32'hA5);

      // Read requested at phase 3, request held high through and past cpu_ready.
      goto_ph(3'd3);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 14'h0003;
      @(negedge clk); #1;
      chk("rd_slot_addr", 32'(ram_addr), 32'h0003);
      chk("rd_slot_we", 32'(ram_we), 32'h0);
      chk("rd_ready_early", 32'(cpu_ready), 32'h0);
      @(negedge clk); #1;
      chk("rd_ready", 32'(cpu_ready), 32'h1);
      chk("rd_dout", 32'(cpu_dout), 32'h77);
      bad = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk); #1;
         if (cpu_ready !== 1'b0 || ram_we !== 1'b0) bad++;
         if (tb_ph == 3'd4) chk("b2b_idle_slot_addr", 32'(ram_addr), 32'h00A1);
      end
      chk("b2b_no_second_access", 32'(bad), 32'h0);
      @(negedge clk);
      cpu_req = 1'b0;
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_addr = 14'h1234;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk); #1;
         chk($sformatf("b2b_ready_k%0d", k), 32'(cpu_ready), (k == 6) ? 32'h1 : 32'h0);
         if (k == 6) chk("b2b_dout", 32'(cpu_dout), 32'hA5);
      end
      @(negedge clk);
      cpu_req = 1'b0;

      // Request arriving exactly in the slot phase waits a full period.
      goto_ph(3'd4);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 14'h0003;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk); #1;
         chk($sformatf("slot_req_ready_k%0d", k), 32'(cpu_ready), (k == 9) ? 32'h1 : 32'h0);
         if (k == 9) chk("slot_req_dout", 32'(cpu_dout), 32'h77);
      end
      @(negedge clk);
      cpu_req = 1'b0;

      // Reset while a write is pending at phase 3.
      goto_ph(3'd2);
      cpu_req  = 1'b1;
      cpu_we   = 1'b1;
      cpu_addr = 14'h0100;
      cpu_din  = 8'h5A;
      @(negedge clk);
      reset   = 1'b1;
      cpu_req = 1'b0;
      #1;
      chk("mid_rst_ram_addr", 32'(ram_addr), 32'h0);
      chk("mid_rst_ram_we", 32'(ram_we), 32'h0);
      chk("mid_rst_ram_din", 32'(ram_din), 32'h0);
      chk("mid_rst_cpu_ready", 32'(cpu_ready), 32'h0);
      chk("mid_rst_cpu_dout", 32'(cpu_dout), 32'h0);
      chk("mid_rst_char_q", 32'(char_q), 32'h0);
      chk("mid_rst_attr_q", 32'(attr_q), 32'h0);
      chk("mid_rst_crtc_ce", 32'(crtc_ce), 32'h0);
      chk("mid_rst_fetch_valid", 32'(fetch_valid), 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst_phase0_addr", 32'(ram_addr), 32'h00A0);
      chk("post_rst_crtc_ce", 32'(crtc_ce), 32'h0);
      bad = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk); #1;
         if (cpu_ready !== 1'b0 || ram_we !== 1'b0) bad++;
         if (k == 7) chk("post_rst_ce_ph7", 32'(crtc_ce), 32'h1);
      end
      chk("post_rst_no_access", 32'(bad), 32'h0);
      chk("post_rst_mem_untouched", 32'(mem[14'h0100]), 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
